fifo_write_ctrl: RTL and testbench

FIFO_WRITE_CTRL -- requirements
Module: fifo_write_ctrl

---
 rtl/fifo_write_ctrl.sv | 85 ++++++++
 tb/tb_fifo_write_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fifo_write_ctrl.sv
// Write-side controller of an asynchronous FIFO: binary/Gray write pointer,
// read-pointer synchroniser, write-domain occupancy and full/overflow flags.
module fifo_write_ctrl #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 3,
  parameter int AFULL_TH    = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_s,
  input  logic              rst,
  input  logic              write_signal,
  input  logic [DATA_W-1:0] din,
  input  logic [ADDR_W:0]   rd_ptr_gray,
  input  logic              clr_overflow,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W:0]   wr_ptr_gray,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   level,
  output logic              overflow
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_V = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] AFULL_V = AFULL_TH[ADDR_W:0];

  logic [ADDR_W:0] wr_bin;
  logic [ADDR_W:0] wr_bin_next;
  logic [ADDR_W:0] rd_sync_q [SYNC_STAGES];
  logic [ADDR_W:0] rd_bin_sync;

  // Handshake: write_signal is a request with no back-pressure. wr_en marks
  // acceptance in the same cycle (request and not full); a request seen while
  // full is dropped, the pointer holds, and the event is latched in overflow.
  assign wr_en   = write_signal & ~full;
  assign wr_data = din;
  assign wr_addr = wr_bin[ADDR_W-1:0];

  always_comb begin
    wr_bin_next = wr_bin;
    if (wr_en) wr_bin_next = wr_bin + 1'b1;
  end

  // Gray pointer is registered from the next binary value so it leaves the
  // domain straight from a flop and always matches gray(wr_bin).
  always_ff @(posedge clk_s or posedge rst) begin
    if (rst) begin
      wr_bin      <= '0;
      wr_ptr_gray <= '0;
    end else begin
      wr_bin      <= wr_bin_next;
      wr_ptr_gray <= wr_bin_next ^ (wr_bin_next >> 1);
    end
  end

  always_ff @(posedge clk_s or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) rd_sync_q[i] <= '0;
    end else begin
      rd_sync_q[0] <= rd_ptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) rd_sync_q[i] <= rd_sync_q[i-1];
    end
  end

  // Gray to binary: each bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rd_bin_sync = '0;
    for (int i = 0; i <= ADDR_W; i++)
      rd_bin_sync[i] = ^(rd_sync_q[SYNC_STAGES-1] >> i);
  end

  assign level       = wr_bin - rd_bin_sync;
  assign full        = (level == DEPTH_V);
  assign almost_full = (level >= AFULL_V);

  // Set wins over clear when both happen on the same edge.
  always_ff @(posedge clk_s or posedge rst) begin
    if (rst)                       overflow <= 1'b0;
    else if (write_signal && full) overflow <= 1'b1;
    else if (clr_overflow)         overflow <= 1'b0;
  end

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// Directed and randomized bench for fifo_write_ctrl against a count-based
// model of the write side (accepted writes, delayed view of the read pointer).
module tb_fifo_write_ctrl;

  localparam int DW = 8, AW = 3, AF = 6, SS = 2;
  localparam int MOD = 1 << (AW + 1), DEPTH = 1 << AW;

  logic          clk_s = 1'b0;
  logic          rst, write_signal, clr_overflow;
  logic [DW-1:0] din;
  logic [AW:0]   rd_ptr_gray;
  logic          wr_en, full, almost_full, overflow;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW:0]   wr_ptr_gray, level;

  fifo_write_ctrl #(.DATA_W(DW), .ADDR_W(AW), .AFULL_TH(AF), .SYNC_STAGES(SS)) dut (
    .clk_s(clk_s), .rst(rst), .write_signal(write_signal), .din(din),
    .rd_ptr_gray(rd_ptr_gray), .clr_overflow(clr_overflow), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ptr_gray(wr_ptr_gray),
    .full(full), .almost_full(almost_full), .level(level), .overflow(overflow)
  );

  always #5 clk_s = ~clk_s;

  int checks = 0, errors = 0;

  // Reference model: counts of writes/reads as plain integers.
  int m_wr, m_rd, m_rd_sync, m_ov;
  int rd_pipe[$];
  logic [AW:0] prev_g;

  function automatic logic [AW:0] gray(input int b);
    logic [AW:0] x;
    x = b[AW:0];
    return x ^ (x >> 1);
  endfunction

  function automatic int m_level();
    return ((m_wr - m_rd_sync) % MOD + MOD) % MOD;
  endfunction

  function automatic bit m_full();
    return m_level() == DEPTH;
  endfunction

  function automatic void model_reset();
    m_wr = 0; m_ov = 0; m_rd_sync = 0;
    rd_pipe = {};
    for (int i = 0; i < SS; i++) rd_pipe.push_back(0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("wr_en", wr_en, write_signal && !m_full());
    chk("wr_addr", wr_addr, m_wr % DEPTH);
    chk("wr_data", wr_data, din);
    chk("wr_ptr_gray", wr_ptr_gray, gray(m_wr));
    chk("level", level, m_level());
    chk("full", full, m_full());
    chk("almost_full", almost_full, m_level() >= AF);
    chk("overflow", overflow, m_ov);
  endtask

  // Drive one cycle's inputs, check before the edge, advance model at the edge.
  task automatic step(input logic ws, input logic [DW-1:0] d, input logic clr);
    bit f;
    write_signal = ws; din = d; clr_overflow = clr; rd_ptr_gray = gray(m_rd);
    #1 check_all();
    @(posedge clk_s);
    if (rst) model_reset();
    else begin
      f = m_full();
      if (ws && f) m_ov = 1;
      else if (clr) m_ov = 0;
      if (ws && !f) m_wr++;
      rd_pipe.push_back(m_rd);
      void'(rd_pipe.pop_front());
      m_rd_sync = rd_pipe[0];
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; m_rd = 0; rd_ptr_gray = '0;
    model_reset();
    #1 check_all();
    @(posedge clk_s);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; write_signal = 1'b1; din = '0; clr_overflow = 1'b0;
    m_rd = 0; rd_ptr_gray = '0;
    model_reset();
    #2;
    chk("rst_wr_en", wr_en, 1);
    chk("rst_gray", wr_ptr_gray, 0);
    chk("rst_level", level, 0);
    do_reset();

    // Fill from empty
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, DW'(16 + i), 1'b0);
      if (i == 4) chk("afull_before_6", almost_full, 0);
      if (i == 5) chk("afull_after_6", almost_full, 1);
    end
    chk("fill_full", full, 1);
    chk("fill_level", level, 8);

    // Overflow set / clear / priority
    step(1'b1, 8'hEE, 1'b0);
    chk("ovf_set", overflow, 1);
    chk("ovf_ptr_hold", wr_ptr_gray, 4'b1100);
    step(1'b0, 8'h00, 1'b1);
    chk("ovf_clr", overflow, 0);
    step(1'b1, 8'h00, 1'b1);
    chk("ovf_set_prio", overflow, 1);
    step(1'b0, 8'h00, 1'b1);

    // Drain latency through the synchroniser
    m_rd = 2;
    step(1'b0, 8'h00, 1'b0);
    chk("drain_edge1_full", full, 1);
    step(1'b0, 8'h00, 1'b0);
    chk("drain_edge2_full", full, 0);
    chk("drain_level", level, 6);

    // Pointer wrap with the read side tracking the writer
    do_reset();
    for (int i = 0; i < 20; i++) begin
      m_rd = m_wr;
      prev_g = gray(m_wr);
      if (i == 15) chk("pre_wrap_gray", wr_ptr_gray, 4'b1000);
      step(1'b1, DW'($urandom_range(0, 255)), 1'b0);
      chk("gray_one_bit", $countones(wr_ptr_gray ^ prev_g), 1);
      chk("wrap_no_full", full, 0);
      if (i == 15) chk("wrap_gray", wr_ptr_gray, 0);
    end

    // Randomized traffic with a lagging reader
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if (m_rd < m_wr && $urandom_range(0, 3) < (i < 150 ? 1 : 3)) m_rd++;
      step($urandom_range(0, 3) != 0, DW'($urandom_range(0, 255)),
           $urandom_range(0, 7) == 0);
    end

    // Mid-operation asynchronous reset pulse between edges
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, DW'(i), 1'b0);
    chk("pre_pulse_addr", wr_addr, 5);
    rst = 1'b1; m_rd = 0; rd_ptr_gray = '0;
    #1;
    model_reset();
    check_all();
    chk("pulse_gray", wr_ptr_gray, 0);
    #1 rst = 1'b0;
    step(1'b1, 8'h5A, 1'b0);
    chk("post_pulse_addr", wr_addr, 1);
    chk("post_pulse_gray", wr_ptr_gray, 4'b0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
